// File: rtl/vga_conv_window.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3-column shift
// window, gated by a frame-lock FSM that tracks the expected raster coordinate.
module vga_conv_window #(
   parameter int PIX_W    = 8,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 pixel_tick,
   input  logic                 video_on,
   input  logic [9:0]           x_pos,
   input  logic [9:0]           y_pos,
   input  logic [PIX_W-1:0]     pix_in,
   output logic [9*PIX_W-1:0]   win,
   output logic                 win_valid,
   output logic [9:0]           win_x,
   output logic [9:0]           win_y,
   output logic                 locked,
   output logic                 sync_err
);

   localparam int AW = $clog2(H_ACTIVE);
   localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           nxt_state;
   logic [9:0]       exp_x;
   logic [9:0]       exp_y;

   logic [PIX_W-1:0] lb1 [H_ACTIVE];
   logic [PIX_W-1:0] lb2 [H_ACTIVE];
   logic [PIX_W-1:0] col [3][3];   // [column][row], row 0 = oldest line

   logic [AW-1:0]    col_idx;
   logic [PIX_W-1:0] lb1_rd;
   logic [PIX_W-1:0] lb2_rd;
   logic             accept_p0;
   logic             is_origin;
   logic             in_seq;
   logic             interior;

   assign accept_p0 = pixel_tick & video_on & (x_pos < H_LIM) & (y_pos < V_LIM);
   assign col_idx   = x_pos[AW-1:0];
   assign lb1_rd    = lb1[col_idx];
   assign lb2_rd    = lb2[col_idx];
   assign is_origin = (x_pos == 10'd0) && (y_pos == 10'd0);
   assign in_seq    = (x_pos == exp_x) && (y_pos == exp_y);
   assign interior  = (x_pos >= 10'd2) && (y_pos >= 10'd2);

   // (0,0) always (re)locks; otherwise lock survives only an in-sequence sample.
   always_comb begin
      nxt_state = IDLE;
      if (is_origin)
         nxt_state = RUN;
      else if ((state == RUN) && in_seq)
         nxt_state = RUN;
   end

   // Stage p0 -> line buffers: read-before-write shifts each column down a line.
   always_ff @(posedge clk) begin
      if (accept_p0) begin
         lb2[col_idx] <= lb1_rd;
         lb1[col_idx] <= pix_in;
      end
   end

   // Stage p0 -> window columns
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
               col[c][r] <= '0;
      end else if (accept_p0) begin
         for (int r = 0; r < 3; r++) begin
            col[0][r] <= col[1][r];
            col[1][r] <= col[2][r];
         end
         col[2][0] <= lb2_rd;
         col[2][1] <= lb1_rd;
         col[2][2] <= pix_in;
      end
   end

   always_comb begin
      win = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            win[(3*r+c)*PIX_W +: PIX_W] = col[c][r];
   end

   // Stage p0 -> frame-lock state and output flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         exp_x     <= '0;
         exp_y     <= '0;
         win_valid <= 1'b0;
         win_x     <= '0;
         win_y     <= '0;
         sync_err  <= 1'b0;
      end else begin
         win_valid <= 1'b0;
         sync_err  <= 1'b0;
         if (accept_p0) begin
            state     <= nxt_state;
            sync_err  <= (state == RUN) && !is_origin && !in_seq;
            win_valid <= (nxt_state == RUN) && interior;
            // Centre only moves with a valid window, so it can never wrap below zero.
            if ((nxt_state == RUN) && interior) begin
               win_x <= x_pos - 10'd1;
               win_y <= y_pos - 10'd1;
            end
            if (x_pos < H_LAST) begin
               exp_x <= x_pos + 10'd1;
               exp_y <= y_pos;
            end else if (y_pos < V_LAST) begin
               exp_x <= '0;
               exp_y <= y_pos + 10'd1;
            end else begin
               exp_x <= '0;
               exp_y <= '0;
            end
         end
      end
   end

   assign locked = (state == RUN);

endmodule

// File: tb/tb_vga_conv_window.sv
// Self-checking bench for vga_conv_window: an image/raster model checked every
// clock, plus literal expectations for the first window, pulse counts and lock.
module tb_vga_conv_window;
   localparam int PW = 8;
   localparam int H  = 16;
   localparam int V  = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pixel_tick = 1'b0;
   logic          video_on = 1'b0;
   logic [9:0]    x_pos = '0;
   logic [9:0]    y_pos = '0;
   logic [PW-1:0] pix_in = '0;
   logic [9*PW-1:0] win;
   logic          win_valid;
   logic [9:0]    win_x;
   logic [9:0]    win_y;
   logic          locked;
   logic          sync_err;

   vga_conv_window #(.PIX_W(PW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .video_on(video_on),
      .x_pos(x_pos), .y_pos(y_pos), .pix_in(pix_in), .win(win), .win_valid(win_valid),
      .win_x(win_x), .win_y(win_y), .locked(locked), .sync_err(sync_err));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Behavioural model: the image as written so far plus raster-lock bookkeeping.
   logic [PW-1:0]   img [V][H];
   bit              m_run;
   int              m_ex, m_ey;
   bit              m_valid, m_serr;
   logic [9:0]      m_wx, m_wy;
   logic [9*PW-1:0] m_win, last_win;
   bit              acc;
   int              ax, ay;

   int              n_valid = 0;
   int              n_serr  = 0;
   int              rec = 0;
   logic [91:0]     qa[$];
   logic [91:0]     qb[$];
   bit              want_first = 0;
   logic [9*PW-1:0] first_w;
   logic [9:0]      first_x, first_y;

   always @(posedge clk or negedge reset_n) begin
      acc = 0;
      m_valid = 0;
      m_serr  = 0;
      if (!reset_n) begin
         m_run = 0; m_ex = 0; m_ey = 0; m_wx = '0; m_wy = '0;
      end else begin
         acc = pixel_tick && video_on && (x_pos < H) && (y_pos < V);
         if (acc) begin
            ax = int'(x_pos);
            ay = int'(y_pos);
            img[ay][ax] = pix_in;
            if (ax == 0 && ay == 0)
               m_run = 1;
            else if (m_run && !(ax == m_ex && ay == m_ey)) begin
               m_run = 0;
               m_serr = 1;
            end
            m_valid = m_run && ax >= 2 && ay >= 2;
            if (m_valid) begin
               m_wx = 10'(ax - 1);
               m_wy = 10'(ay - 1);
               for (int r = 0; r < 3; r++)
                  for (int c = 0; c < 3; c++)
                     m_win[(3*r+c)*PW +: PW] = img[ay-2+r][ax-2+c];
            end
            if (ax < H - 1) begin m_ex = ax + 1; m_ey = ay; end
            else if (ay < V - 1) begin m_ex = 0; m_ey = ay + 1; end
            else begin m_ex = 0; m_ey = 0; end
         end
      end
      #1;
      chk("win_valid", 96'(win_valid), 96'(m_valid));
      chk("sync_err",  96'(sync_err),  96'(m_serr));
      chk("locked",    96'(locked),    96'(m_run));
      chk("win_x",     96'(win_x),     96'(m_wx));
      chk("win_y",     96'(win_y),     96'(m_wy));
      if (!reset_n)
         chk("win_reset", 96'(win), 96'(0));
      else if (m_valid)
         chk("win_data", 96'(win), 96'(m_win));
      else if (!acc)
         chk("win_hold", 96'(win), 96'(last_win));
      last_win = win;
      if (win_valid) begin
         n_valid++;
         if (rec == 1) qa.push_back({win_x, win_y, win});
         if (rec == 2) qb.push_back({win_x, win_y, win});
         if (want_first) begin
            first_w = win; first_x = win_x; first_y = win_y;
            want_first = 0;
         end
      end
      if (sync_err) n_serr++;
   end

   task automatic send(input int x, input int y, input bit von = 1'b1);
      @(negedge clk);
      pixel_tick = 1'b1;
      video_on   = von;
      x_pos      = 10'(x);
      y_pos      = 10'(y);
      pix_in     = 8'((x + y) % 256);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pixel_tick = 1'b0;
         video_on   = 1'b0;
      end
   endtask

   // Raster from (x0,y0) to (x1,y1) inclusive; gap = clocks per pixel.
   task automatic raster(input int x0, input int y0, input int x1, input int y1,
                         input int gap, input bit blank);
      for (int i = y0 * H + x0; i <= y1 * H + x1; i++) begin
         send(i % H, i / H);
         idle(gap - 1);
         if (blank && (i % H) == H - 1) begin
            send(700, i / H);
            send(3, i / H, 1'b0);
            idle(1);
         end
      end
      idle(2);
   endtask

   int v0, s0;
   localparam logic [71:0] FIRST_WIN = 72'h04_03_02_03_02_01_02_01_00;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_win_valid", 96'(win_valid), 96'(0));
      chk("reset_locked",    96'(locked),    96'(0));
      chk("reset_win",       96'(win),       96'(0));
      reset_n = 1'b1;

      // Frame A: one pixel per clock
      rec = 1; want_first = 1; v0 = n_valid;
      raster(0, 0, H - 1, V - 1, 1, 1'b0);
      chk("frameA_pulses", 96'(n_valid - v0), 96'((H - 2) * (V - 2)));
      chk("first_centre_x", 96'(first_x), 96'(1));
      chk("first_centre_y", 96'(first_y), 96'(1));
      chk("first_win", 96'(first_w), 96'(FIRST_WIN));
      chk("frameA_locked", 96'(locked), 96'(1));

      // Frame B: one pixel per 4 clocks with blanking and off-screen ticks
      rec = 2; v0 = n_valid; s0 = n_serr;
      raster(0, 0, H - 1, V - 1, 4, 1'b1);
      rec = 0;
      chk("frameB_pulses", 96'(n_valid - v0), 96'((H - 2) * (V - 2)));
      chk("frameB_no_sync_err", 96'(n_serr - s0), 96'(0));
      chk("seq_len", 96'(qb.size()), 96'(qa.size()));
      for (int i = 0; i < qa.size() && i < qb.size(); i++)
         chk("seq_equal", 96'(qb[i]), 96'(qa[i]));

      // Mid-stream start after reset
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      v0 = n_valid;
      raster(5, 3, H - 1, V - 1, 1, 1'b0);
      chk("midstream_no_valid", 96'(n_valid - v0), 96'(0));
      chk("midstream_unlocked", 96'(locked), 96'(0));

      // Skip pixel while locked
      v0 = n_valid; s0 = n_serr;
      raster(0, 0, 10, 4, 1, 1'b0);
      chk("origin_locks", 96'(locked), 96'(1));
      raster(12, 4, H - 1, V - 1, 1, 1'b0);
      chk("skip_sync_err_once", 96'(n_serr - s0), 96'(1));
      chk("skip_valid_count", 96'(n_valid - v0), 96'(2 * (H - 2) + 9));
      chk("skip_unlocked", 96'(locked), 96'(0));

      // Reset asserted during row 5
      raster(0, 0, 7, 5, 1, 1'b0);
      chk("pre_reset_locked", 96'(locked), 96'(1));
      send(8, 5);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_locked", 96'(locked), 96'(0));
      chk("async_reset_valid", 96'(win_valid), 96'(0));
      chk("async_reset_win", 96'(win), 96'(0));
      chk("async_reset_win_x", 96'(win_x), 96'(0));
      idle(2);
      reset_n = 1'b1;
      v0 = n_valid;
      raster(3, 5, H - 1, 6, 1, 1'b0);
      chk("post_reset_no_valid", 96'(n_valid - v0), 96'(0));
      want_first = 1; v0 = n_valid;
      raster(0, 0, H - 1, V - 1, 1, 1'b0);
      chk("post_reset_first_x", 96'(first_x), 96'(1));
      chk("post_reset_first_y", 96'(first_y), 96'(1));
      chk("post_reset_first_win", 96'(first_w), 96'(FIRST_WIN));
      chk("post_reset_pulses", 96'(n_valid - v0), 96'((H - 2) * (V - 2)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
